// File: rtl/face_det_pkg.sv
// Shared types and constants for the face-detection front end: luma weights,
// engine FSM states, the 8-bit pixel triple and a constant ceil-log2 helper.
package face_det_pkg;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fsm_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic int clog2(longint unsigned v);
    longint unsigned t;
    int r;
    r = 0;
    t = (v > 0) ? v - 1 : 0;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// First pipeline stage of the integral-image engine: registered RGB -> 8-bit luma
// with a clock enable, g = (77R + 150G + 29B) >> 8, truncated.
module rgb_to_luma
  import face_det_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  pixel_t     pix,
  output logic [7:0] luma
);

  function automatic logic [7:0] luma_of(pixel_t p);
    logic [15:0] acc;
    acc = 16'(LUMA_R) * 16'(p.r) + 16'(LUMA_G) * 16'(p.g) + 16'(LUMA_B) * 16'(p.b);
    return 8'(acc >> 8);
  endfunction

  always_ff @(posedge clk) begin
    if (en) luma <= luma_of(pix);
  end

endmodule

// File: rtl/integral_image_engine.sv
// Streaming integral-image generator with a single-row line buffer and valid/ready on both sides.
// Define SQ_INTEGRAL_EN to add the squared-luma integral on out_sq_ii.
module integral_image_engine
  import face_det_pkg::*;
#(
  parameter int IMG_W = 20,
  parameter int IMG_H = 20,
  parameter int PIX_W = 8,
  parameter int ACC_W = 17
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] VGA_R_in,
  input  logic [PIX_W-1:0] VGA_G_in,
  input  logic [PIX_W-1:0] VGA_B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_ii,
  output logic             out_eol,
  output logic             out_eof
`ifdef SQ_INTEGRAL_EN
  ,
  output logic [2*ACC_W-1:0] out_sq_ii
`endif
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);
  localparam int SW = 2 * ACC_W;

  if (ACC_W < clog2(longint'(IMG_W) * IMG_H * 255 + 1)) begin : g_acc_w_check
    $error("ACC_W too narrow for IMG_W*IMG_H*255");
  end

  function automatic logic [7:0] msb8(logic [PIX_W-1:0] c);
    return 8'({c, 8'd0} >> PIX_W);
  endfunction

  fsm_state_t      state;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic            en;
  logic            accept;
  logic            take;
  logic            last;
  logic [XW-1:0]   px;
  logic [YW-1:0]   py;
  pixel_t          pix_p0;

  always_comb begin
    en       = !out_valid || out_ready;
    in_ready = en && (state != FLUSH);
    accept   = in_valid && in_ready;
    take     = accept && (in_sof || state == RUN);
    px       = in_sof ? '0 : x_cnt;
    py       = in_sof ? '0 : y_cnt;
    last     = take && (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
    pix_p0   = '{r: msb8(VGA_R_in), g: msb8(VGA_G_in), b: msb8(VGA_B_in)};
  end

  // Frame control: a mid-frame sof simply restarts the counters at (0,0).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (take) begin
        if (last) begin
          state <= FLUSH;
          x_cnt <= '0;
          y_cnt <= '0;
        end else begin
          state <= RUN;
          if (px == XW'(IMG_W - 1)) begin
            x_cnt <= '0;
            y_cnt <= py + 1'b1;
          end else begin
            x_cnt <= px + 1'b1;
            y_cnt <= py;
          end
        end
      end else if (state == FLUSH && out_valid && out_ready && out_eof) begin
        state <= IDLE;
      end
    end
  end

  // ---- S1: luma conversion and pixel coordinates ----
  logic [7:0]    g_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic          vld_p1;

  rgb_to_luma u_luma (
    .clk  (CLK),
    .en   (en),
    .pix  (pix_p0),
    .luma (g_p1)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) vld_p1 <= 1'b0;
    else if (en)  vld_p1 <= take;
  end

  always_ff @(posedge CLK) begin
    if (en) begin
      x_p1 <= px;
      y_p1 <= py;
    end
  end

  // ---- S2: row accumulation plus the line-buffer column above ----
  logic [ACC_W-1:0] lb [IMG_W];
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_nxt;
  logic [ACC_W-1:0] ii_p1;

  always_comb begin
    row_nxt = (x_p1 == '0) ? ACC_W'(g_p1) : row_sum + ACC_W'(g_p1);
    ii_p1   = row_nxt + ((y_p1 == '0) ? '0 : lb[x_p1]);
  end

  always_ff @(posedge CLK) begin
    if (en && vld_p1) begin
      row_sum  <= row_nxt;
      lb[x_p1] <= ii_p1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
      out_ii    <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_ii  <= ii_p1;
        out_eol <= (x_p1 == XW'(IMG_W - 1));
        out_eof <= (x_p1 == XW'(IMG_W - 1)) && (y_p1 == YW'(IMG_H - 1));
      end
    end
  end

`ifdef SQ_INTEGRAL_EN
  logic [SW-1:0] sq_lb [IMG_W];
  logic [SW-1:0] sq_row;
  logic [SW-1:0] sq_nxt;
  logic [SW-1:0] sq_ii_p1;
  logic [15:0]   g2_p1;

  always_comb begin
    g2_p1    = 16'(g_p1) * 16'(g_p1);
    sq_nxt   = (x_p1 == '0) ? SW'(g2_p1) : sq_row + SW'(g2_p1);
    sq_ii_p1 = sq_nxt + ((y_p1 == '0) ? '0 : sq_lb[x_p1]);
  end

  always_ff @(posedge CLK) begin
    if (en && vld_p1) begin
      sq_row      <= sq_nxt;
      sq_lb[x_p1] <= sq_ii_p1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                out_sq_ii <= '0;
    else if (en && vld_p1)       out_sq_ii <= sq_ii_p1;
  end
`endif

endmodule

// File: tb/tb_integral_image_engine.sv
// Scoreboard bench for integral_image_engine: a rectangle-sum reference model feeds an
// expected queue; a negedge monitor pops and compares. Covers SQ_INTEGRAL_EN when defined.
module tb_integral_image_engine;

  localparam int W = 20;
  localparam int H = 20;
  localparam int PW = 8;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [PW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_ii;
  logic          out_eol;
  logic          out_eof;
`ifdef SQ_INTEGRAL_EN
  logic [2*AW-1:0] out_sq_ii;
`endif

  integral_image_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ACC_W(AW)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .VGA_R_in  (r_in),
    .VGA_G_in  (g_in),
    .VGA_B_in  (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ii    (out_ii),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
`ifdef SQ_INTEGRAL_EN
    ,
    .out_sq_ii (out_sq_ii)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint ii;
    longint sq;
    bit     eol;
    bit     eof;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     cyc = 0;
  bit     rdy_rand = 1'b0;
  int     first_out_cyc = -1;
  longint last_eof_ii = -1;
  longint last_eof_sq = -1;

  // Reference model state: luma image of the current frame and raster position.
  int lum [H][W];
  bit inframe = 1'b0;
  int pos = 0;

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input int r, input int g, input int b, input bit sof);
    exp_t e;
    int x, y;
    if (sof) begin
      inframe = 1'b1;
      pos = 0;
    end
    if (!inframe) return;
    x = pos % W;
    y = pos / W;
    lum[y][x] = (77 * r + 150 * g + 29 * b) / 256;
    e.ii = 0;
    e.sq = 0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++) begin
        e.ii += lum[j][i];
        e.sq += lum[j][i] * lum[j][i];
      end
    e.eol = (x == W - 1);
    e.eof = (x == W - 1) && (y == H - 1);
    sb.push_back(e);
    pos++;
    if (pos == W * H) inframe = 1'b0;
  endtask

  // Monitor: pop on every handshake, and require held outputs during a stall.
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_ii;
  logic          prev_eol, prev_eof;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!(out_valid && out_ii == prev_ii && out_eol == prev_eol && out_eof == prev_eof)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b ii=%0d expected v=1 ii=%0d", out_valid, out_ii, prev_ii);
        end
      end
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got ii=%0d expected no sample", out_ii);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_ii", out_ii, e.ii);
          check("out_eol", out_eol, e.eol);
          check("out_eof", out_eof, e.eof);
`ifdef SQ_INTEGRAL_EN
          check("out_sq_ii", out_sq_ii, e.sq);
          if (out_eof) last_eof_sq = out_sq_ii;
`endif
          if (out_eof) last_eof_ii = out_ii;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_ii    = out_ii;
      prev_eol   = out_eol;
      prev_eof   = out_eof;
    end
  end

  task automatic send(input int r, input int g, input int b, input bit sof, output int acc);
    r_in = PW'(r);
    g_in = PW'(g);
    b_in = PW'(b);
    in_sof = sof;
    in_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        model_accept(r, g, b, sof);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        return;
      end
    end
    check("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int val);
    int acc, r, g, b;
    for (int p = 0; p < W * H; p++) begin
      if (mode == 0) begin
        r = val; g = val; b = val;
      end else begin
        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      end
      send(r, g, b, p == 0, acc);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000 && (sb.size() != 0 || out_valid); k++) @(posedge clk);
    if (k == 3000) check("drain_timeout", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ii", out_ii, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_out_eof", out_eof, 0);
  endtask

  initial begin
    int acc, first_acc;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: stray pixels in IDLE are dropped, then a flat luma-1 frame.
    for (int p = 0; p < 3; p++) send(1, 1, 1, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_output", first_out_cyc, -1);
    send(1, 1, 1, 1'b1, first_acc);
    for (int p = 1; p < W * H; p++) send(1, 1, 1, 1'b0, acc);
    drain();
    check("latency", first_out_cyc - first_acc, 2);
    check("flat1_final", last_eof_ii, 400);

    // Test 2: saturated flat frame must not overflow.
    last_eof_ii = -1;
    send_frame(0, 255);
    drain();
    check("flat255_final", last_eof_ii, 102000);

    // Test 3: random pixels with a randomly stalling consumer.
    rdy_rand = 1'b1;
    send_frame(1, 0);
    drain();

    // Test 4: sof reasserted at pixel 137 restarts the frame.
    for (int p = 0; p < 137; p++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), p == 0, acc);
    send_frame(1, 0);
    drain();

    // Test 5: reset at pixel 250, then a full frame.
    for (int p = 0; p < 250; p++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), p == 0, acc);
    rst_n = 1'b0;
    sb.delete();
    inframe = 1'b0;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(1, 0);
    drain();

    // Test 6: flat luma 2, which also exercises the squared integral when enabled.
    rdy_rand = 1'b0;
    last_eof_ii = -1;
    send_frame(0, 2);
    drain();
    check("flat2_final", last_eof_ii, 800);
`ifdef SQ_INTEGRAL_EN
    check("flat2_sq_final", last_eof_sq, 1600);
`endif

    check("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
